// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single borrow flip-flop. Operands and result each use a valid/ready handshake.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_ovf;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_next;

  // Operands shift right each RUN cycle, so bit 0 is always the bit being processed
  // and, on the last step, holds the original MSB used by the overflow rule.
  assign w_a_bit   = r_a[0];
  assign w_b_bit   = r_b[0];
  assign w_d       = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
  assign w_last    = (r_cnt == LAST_BIT);
  assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready/out_valid decode state only; upstream must hold in_valid and operands
  // until accepted, and the result stays stable while out_valid is high.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff  <= w_sr_next;
            r_bout  <= w_br_next;
            r_ovf   <= (w_a_bit != w_b_bit) && (w_d != w_a_bit);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor (WIDTH = 4): directed scenarios plus randomized
// operations, scored against an arithmetic reference model.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;
  int acc_cnt = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] res_q[$];
  time          acc_t[$];

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: packs {ovf, bout, diff}
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0]   full;
    logic [W-1:0] d;
    logic         o;
    full = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    d    = full[W-1:0];
    o    = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {o, full[W], d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected pushed at accept, compared at result handshake
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(a, b, bin));
      acc_t.push_back($time);
      acc_cnt++;
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("sb_diff", 32'(diff), 32'(e[W-1:0]));
        check("sb_bout", 32'(bout), 32'(e[W]));
        check("sb_ovf",  32'(ovf),  32'(e[W+1]));
      end
      res_q.push_back({ovf, bout, diff});
    end
  end

  // Driver tasks
  task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    int k;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    if (in_ready) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec++;
  endtask

  task automatic wait_result(input int exp_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
    check("out_valid_after_take", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int base;
    int rbase;
    int k;
    logic [W-1:0] ra, rb;
    logic rbin;

    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Wrap with borrow
    accept_op(4'b0001, 4'b1111, 1'b0);
    wait_result(4);
    check("wrap_diff", 32'(diff), 32'b0010);
    check("wrap_bout", 32'(bout), 32'd1);
    check("wrap_ovf", 32'(ovf), 32'd0);
    take_result();

    // Signed overflow
    accept_op(4'b1000, 4'b0001, 1'b0);
    wait_result(4);
    check("ovf_diff", 32'(diff), 32'b0111);
    check("ovf_bout", 32'(bout), 32'd0);
    check("ovf_ovf", 32'(ovf), 32'd1);
    take_result();

    // Borrow-in propagation
    accept_op(4'b0101, 4'b0101, 1'b1);
    wait_result(4);
    check("bin_diff", 32'(diff), 32'b1111);
    check("bin_bout", 32'(bout), 32'd1);
    check("bin_ovf", 32'(ovf), 32'd0);
    take_result();

    // Back-pressure with input noise
    accept_op(4'b1111, 4'b0001, 1'b0);
    wait_result(4);
    base = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_diff", 32'(diff), 32'b1110);
      check("bp_bout", 32'(bout), 32'd0);
      check("bp_ovf", 32'(ovf), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      in_valid = ~in_valid;
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_no_accept", 32'(acc_cnt), 32'(base));
    take_result();

    // Back-to-back
    base = acc_cnt;
    rbase = res_q.size();
    @(negedge clk);
    a = 4'd3; b = 4'd1; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (acc_cnt < base + 1 && k < 20) begin @(negedge clk); k++; end
    a = 4'd0; b = 4'd1; bin = 1'b0;
    k = 0;
    while (acc_cnt < base + 2 && k < 20) begin @(negedge clk); k++; end
    in_valid = 1'b0;
    k = 0;
    while (res_q.size() < rbase + 2 && k < 20) begin @(negedge clk); k++; end
    out_ready = 1'b0;
    n_vec += 2;
    check("b2b_accepts", 32'(acc_cnt - base), 32'd2);
    check("b2b_results", 32'(res_q.size() - rbase), 32'd2);
    if (acc_cnt >= base + 2 && res_q.size() >= rbase + 2) begin
      check("b2b_spacing", 32'(acc_t[base + 1] - acc_t[base]), 32'd60);
      check("b2b_res0", 32'(res_q[rbase]), 32'b000010);
      check("b2b_res1", 32'(res_q[rbase + 1]), 32'b011111);
    end

    // Reset mid-RUN
    accept_op(4'b1010, 4'b0011, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_rst_no_result", 32'(out_valid), 32'd0);
    end
    accept_op(4'b0110, 4'b0010, 1'b0);
    wait_result(4);
    check("post_rst_diff", 32'(diff), 32'b0100);
    check("post_rst_bout", 32'(bout), 32'd0);
    check("post_rst_ovf", 32'(ovf), 32'd0);
    take_result();

    // Randomized operations with idle gaps and back-pressure noise
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rbin = 1'($urandom_range(0, 1));
      accept_op(ra, rb, rbin);
      wait_result(4);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      end
      in_valid = 1'b0;
      take_result();
    end

    repeat (2) @(negedge clk);
    check("accept_count", 32'(acc_cnt), 32'(n_vec));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial ripple-borrow subtractor: the inverse of the team's ripple-carry adder, computing `diff = a - b - bin` one bit per clock, LSB first, through a single borrow flip-flop. It accepts operands over a valid/ready handshake and returns the difference, borrow-out and signed overflow over a second valid/ready handshake. Parameterised width. It is used where area matters more than latency, and as the subtract path paired with the adder in the arithmetic datapath.

## Interface
- `WIDTH`, default 4: operand/result width in bits; legal range ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands present on `a`, `b`, `bin`.
- `in_ready`  out  1  block can accept operands; equals (state == IDLE).
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result present; equals (state == DONE).
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow-out; 1 iff unsigned `a < b + bin`.
- `ovf`  out  1  two's-complement overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - On `in_valid && in_ready` at an edge, latch `a`, `b` and `bin`.
  - Load the borrow register with `bin` and clear the bit counter.
  - Go to RUN.
- **RUN:**
  - Each edge processes bit `i` (the counter value) as follows:
    - `d_i = a_i ^ b_i ^ br`
    - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
    - shift `d_i` into the MSB of an internal shift register.
  - Counter width is `$clog2(WIDTH)`.
  - At the edge processing bit `WIDTH-1`:
    - load `diff` with the completed result, `bout` with the final borrow, and `ovf` per the rule above;
    - go to DONE.
- **DONE:**
  - Hold `out_valid`, `diff`, `bout` and `ovf` stable.
  - On `out_valid && out_ready` at an edge, go to IDLE.
- **Output registers:**
  - `diff`, `bout` and `ovf` are registered.
  - They change only on the RUN→DONE edge and retain the last result in IDLE and RUN.
- **Operand isolation:** Operands are sampled only at accept. Changes to `a`, `b` or `bin` during RUN or DONE have no effect.
- **No queuing:** `in_valid` while `in_ready` = 0 is ignored; the upstream block must hold it.
- **Reset (asynchronous, any state including mid-RUN):**
  - Go to IDLE; `diff` = 0, `bout` = 0, `ovf` = 0, `out_valid` = 0; counter, borrow and shift register cleared.
  - `in_ready` reads 1 while in reset, but no accept occurs until `rst_n` is high at a rising edge.
  - A partial operation is discarded and no result is emitted.

## Timing
- Accept at edge T0. Bits 0..WIDTH-1 are processed at edges T1..T_WIDTH.
- `out_valid` rises after edge T_WIDTH, giving a latency of WIDTH cycles from accept to result.
- With `out_ready` = 1, the result handshake is at T_WIDTH+1. `in_ready` rises after that edge, and the next accept is at T_WIDTH+2.
- Maximum throughput is one operation per WIDTH+2 cycles.
- No combinational path runs from `in_valid` or `out_ready` to any output; `in_ready` and `out_valid` decode state only.

## Test plan
All scenarios use WIDTH = 4.
- **Wrap with borrow:** `a`=0001, `b`=1111, `bin`=0 → `diff`=0010, `bout`=1, `ovf`=0; `out_valid` exactly 4 cycles after accept.
- **Signed overflow:** `a`=1000, `b`=0001, `bin`=0 → `diff`=0111, `bout`=0, `ovf`=1.
- **Borrow-in propagation:** `a`=0101, `b`=0101, `bin`=1 → `diff`=1111, `bout`=1, `ovf`=0.
- **Back-pressure:**
  - Run `a`=1111, `b`=0001, `bin`=0, then hold `out_ready`=0 for 5 cycles with `in_valid` pulsing and operands toggling.
  - Required: `diff`=1110, `bout`=0 and `ovf`=0 stable; `in_ready`=0; no new accept.
  - On `out_ready`=1, `in_ready`=1 on the next cycle.
- **Back-to-back:**
  - Hold `in_valid`=1 and `out_ready`=1 with operand pairs (3,1,0) then (0,1,0).
  - Required results: 0010/`bout` 0, then 1111/`bout` 1; accepts are spaced exactly 6 cycles apart.
- **Reset mid-RUN:**
  - Assert `rst_n`=0 two cycles after accepting `a`=1010, `b`=0011.
  - Required: outputs go to 0 immediately, FSM returns to IDLE, and no `out_valid` occurs.
  - A following op `a`=0110, `b`=0010, `bin`=0 → `diff`=0100, `bout`=0, `ovf`=0.
